// File: rtl/search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : search_ctrl
//  Purpose  : Linear-search sequencer for an equality-compare datapath.
//             It scans a synchronous-read memory from lo_addr to hi_addr,
//             wrapping modulo 2^A. It drives the comparator key/enable,
//             samples the combinational match, and reports the first
//             matching address. A search can be resumed past a hit (next)
//             or dropped at any time (abort).
//  Ports    : clk, rst_n                - clock / async active-low reset
//             start, abort, next        - control strobes
//             key, lo_addr, hi_addr     - search arguments, latched on start
//             mem_en, mem_addr          - memory read port (1-cycle latency)
//             cmp_key, cmp_en, cmp_match- comparator interface
//             busy, done, hit, hit_addr - status / result
//  Revision : 1.0  initial release
// ============================================================================
module search_ctrl #(
  parameter int A = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         next,
  input  logic [D-1:0] key,
  input  logic [A-1:0] lo_addr,
  input  logic [A-1:0] hi_addr,
  output logic         mem_en,
  output logic [A-1:0] mem_addr,
  output logic [D-1:0] cmp_key,
  output logic         cmp_en,
  input  logic         cmp_match,
  output logic         busy,
  output logic         done,
  output logic         hit,
  output logic [A-1:0] hit_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [A-1:0] c_one = {{(A-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [A-1:0] r_cur;
  logic [A-1:0] r_last;

  logic w_done_nxt;
  logic w_hit_nxt;
  logic w_load;     // accept a new search: latch key/range
  logic w_inc;      // advance to the next address
  logic w_cap;      // record current address as the hit address
  logic w_at_last;

  assign w_at_last = (r_cur == r_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control. abort overrides everything; in HOLD a
  // simultaneous start beats next.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_hit_nxt   = hit;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_cap       = 1'b0;

    if (abort) begin
      w_state_nxt = IDLE;
      w_hit_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_load      = 1'b1;
            w_hit_nxt   = 1'b0;
            w_state_nxt = RD;
          end
        end
        RD: begin
          w_state_nxt = CMP;
        end
        CMP: begin
          if (cmp_match) begin
            w_hit_nxt   = 1'b1;
            w_cap       = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = HOLD;
          end else if (w_at_last) begin
            w_hit_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_inc       = 1'b1;
            w_state_nxt = RD;
          end
        end
        HOLD: begin
          if (start) begin
            w_load      = 1'b1;
            w_hit_nxt   = 1'b0;
            w_state_nxt = RD;
          end else if (next) begin
            w_hit_nxt = 1'b0;
            if (w_at_last) begin
              // Hit was on the final address: nothing left to scan.
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_inc       = 1'b1;
              w_state_nxt = RD;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur    <= '0;
      r_last   <= '0;
      cmp_key  <= '0;
      hit      <= 1'b0;
      hit_addr <= '0;
      done     <= 1'b0;
    end else begin
      done <= w_done_nxt;
      hit  <= w_hit_nxt;
      if (w_load) begin
        cmp_key <= key;
        r_cur   <= lo_addr;
        r_last  <= hi_addr;
      end else if (w_inc) begin
        r_cur <= r_cur + c_one;   // wraps naturally modulo 2^A
      end
      if (w_cap) begin
        hit_addr <= r_cur;
      end
    end
  end

  // Outputs decoded from state only
  assign mem_en   = (r_state == RD);
  assign cmp_en   = (r_state == CMP);
  assign busy     = (r_state == RD) || (r_state == CMP);
  assign mem_addr = r_cur;

endmodule
`default_nettype wire
